// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, immediate-format codes and the decoded bundle type
// shared by the decode stage and its immediate generator.
// pc/imm in the bundle are XLEN_MAX wide; a stage built with a narrower XLEN
// uses only the low XLEN bits.
package decode_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [6:0]          op;
        logic [4:0]          rd;
        logic [2:0]          f3;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [6:0]          f7;
        logic [XLEN_MAX-1:0] imm;
        imm_type_e           imm_type;
        logic                illegal;
    } dec_bundle_t;

    // Every RV immediate fits in 32 bits; widen it by sign extension.
    function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] v);
        return {{(XLEN_MAX-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: purely combinational immediate extraction and legality check for
// the RV32I/RV64I base formats. Illegal words produce imm=0 and IMM_NONE.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0]         instr,
    output logic [XLEN_MAX-1:0] imm,
    output imm_type_e           imm_type,
    output logic                illegal
);

    logic [31:0] imm32;

    // Select the immediate format from the opcode; unknown opcodes are illegal.
    always_comb begin
        imm32    = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                imm32    = {{20{instr[31]}}, instr[31:20]};
                imm_type = IMM_I;
            end
            OPC_STORE: begin
                imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                imm_type = IMM_S;
            end
            OPC_BRANCH: begin
                imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
                imm_type = IMM_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32    = {instr[31:12], 12'b0};
                imm_type = IMM_U;
            end
            OPC_JAL: begin
                imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
                imm_type = IMM_J;
            end
            OPC_OP, OPC_MISC_MEM: begin
                imm32    = '0;
                imm_type = IMM_NONE;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        // Compressed / non-32-bit encodings are not supported by this stage.
        if (instr[1:0] != 2'b11) begin
            illegal  = 1'b1;
        end
        if (illegal) begin
            imm32    = '0;
            imm_type = IMM_NONE;
        end
    end

    assign imm = sext32(imm32);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decode with valid/ready on both sides
// and an optional one-entry skid buffer.
// Optional build macro DECODE_PERF_CNT_EN adds perf_dec_cnt / perf_ill_cnt.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and the out_* bundle holds steady while
// out_valid && !out_ready. flush drops everything held plus the word offered
// in the same cycle.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SKID_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_f3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_f7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]     perf_dec_cnt,
    output logic [31:0]     perf_ill_cnt
`endif
);

    dec_bundle_t         dec;
    dec_bundle_t         out_q;
    dec_bundle_t         skid_q;
    logic                skid_valid;
    logic [XLEN_MAX-1:0] gen_imm;
    imm_type_e           gen_imm_type;
    logic                gen_illegal;
    logic                in_fire;
    logic                out_free;

    imm_gen u_imm_gen (
        .instr    (in_instr),
        .imm      (gen_imm),
        .imm_type (gen_imm_type),
        .illegal  (gen_illegal)
    );

    // Assemble the decoded bundle for the word currently offered by fetch.
    always_comb begin
        dec               = '0;
        dec.pc[XLEN-1:0]  = in_pc;
        dec.op            = in_instr[6:0];
        dec.rd            = in_instr[11:7];
        dec.f3            = in_instr[14:12];
        dec.rs1           = in_instr[19:15];
        dec.rs2           = in_instr[24:20];
        dec.f7            = in_instr[31:25];
        dec.imm           = gen_imm;
        dec.imm_type      = gen_imm_type;
        dec.illegal       = gen_illegal;
    end

    // With a skid, ready is purely registered; without, it looks through.
    assign in_ready = (SKID_EN != 0) ? !skid_valid : (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_free = !out_valid || out_ready;

    // Output and skid registers: refill output from skid first to keep order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire && (SKID_EN != 0)) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_pc       = out_q.pc[XLEN-1:0];
    assign out_op       = out_q.op;
    assign out_rd       = out_q.rd;
    assign out_f3       = out_q.f3;
    assign out_rs1      = out_q.rs1;
    assign out_rs2      = out_q.rs2;
    assign out_f7       = out_q.f7;
    assign out_imm      = out_q.imm[XLEN-1:0];
    assign out_imm_type = out_q.imm_type;
    assign out_illegal  = out_q.illegal;

    // Upper pc/imm bits are only meaningful when XLEN is the full width.
    logic unused_hi;
    assign unused_hi = ^{out_q.pc, out_q.imm};

`ifdef DECODE_PERF_CNT_EN
    // Count delivered bundles and delivered illegal bundles; flush leaves them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_dec_cnt <= '0;
            perf_ill_cnt <= '0;
        end else if (out_valid && out_ready) begin
            perf_dec_cnt <= perf_dec_cnt + 32'd1;
            if (out_q.illegal) begin
                perf_ill_cnt <= perf_ill_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage (XLEN=32 with
// skid, plus an XLEN=64 instance) against a queue-based reference model.
module tb_decode_stage;
    import decode_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [6:0]  out_op;
    logic [4:0]  out_rd;
    logic [2:0]  out_f3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_f7;
    logic [31:0] out_imm;
    logic [2:0]  out_imm_type;
    logic        out_illegal;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_dec_cnt;
    logic [31:0] perf_ill_cnt;
    logic [31:0] perf_dec_cnt_w;
    logic [31:0] perf_ill_cnt_w;
`endif

    logic        rst_w = 1'b1;
    logic        flush_w = 1'b0;
    logic        in_valid_w = 1'b0;
    logic        in_ready_w;
    logic [31:0] in_instr_w = '0;
    logic [63:0] in_pc_w = '0;
    logic        out_valid_w;
    logic        out_ready_w = 1'b0;
    logic [63:0] out_pc_w;
    logic [6:0]  out_op_w;
    logic [4:0]  out_rd_w;
    logic [2:0]  out_f3_w;
    logic [4:0]  out_rs1_w;
    logic [4:0]  out_rs2_w;
    logic [6:0]  out_f7_w;
    logic [63:0] out_imm_w;
    logic [2:0]  out_imm_type_w;
    logic        out_illegal_w;

    decode_stage #(.XLEN(32), .SKID_EN(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_op(out_op), .out_rd(out_rd), .out_f3(out_f3), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_f7(out_f7), .out_imm(out_imm),
        .out_imm_type(out_imm_type), .out_illegal(out_illegal)
`ifdef DECODE_PERF_CNT_EN
        , .perf_dec_cnt(perf_dec_cnt), .perf_ill_cnt(perf_ill_cnt)
`endif
    );

    decode_stage #(.XLEN(64), .SKID_EN(1)) dut_w (
        .clk(clk), .rst(rst_w), .flush(flush_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .in_instr(in_instr_w), .in_pc(in_pc_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_pc(out_pc_w),
        .out_op(out_op_w), .out_rd(out_rd_w), .out_f3(out_f3_w), .out_rs1(out_rs1_w),
        .out_rs2(out_rs2_w), .out_f7(out_f7_w), .out_imm(out_imm_w),
        .out_imm_type(out_imm_type_w), .out_illegal(out_illegal_w)
`ifdef DECODE_PERF_CNT_EN
        , .perf_dec_cnt(perf_dec_cnt_w), .perf_ill_cnt(perf_ill_cnt_w)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  kind;
        logic        ill;
    } ref_t;

    // Immediate values computed as signed integers scaled by the format's
    // implicit low zero bits.
    function automatic ref_t ref_decode(input logic [31:0] ins);
        ref_t        r;
        longint      v;
        logic [11:0] s12;
        logic [11:0] b12;
        logic [19:0] j20;
        v      = 0;
        r.kind = IMM_NONE;
        r.ill  = 1'b0;
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                v = longint'($signed(ins[31:20]));
                r.kind = IMM_I;
            end
            7'b0100011: begin
                s12 = {ins[31:25], ins[11:7]};
                v = longint'($signed(s12));
                r.kind = IMM_S;
            end
            7'b1100011: begin
                b12 = {ins[31], ins[7], ins[30:25], ins[11:8]};
                v = longint'($signed(b12)) * 2;
                r.kind = IMM_B;
            end
            7'b0110111, 7'b0010111: begin
                v = longint'($signed(ins[31:12])) * 4096;
                r.kind = IMM_U;
            end
            7'b1101111: begin
                j20 = {ins[31], ins[19:12], ins[20], ins[30:21]};
                v = longint'($signed(j20)) * 2;
                r.kind = IMM_J;
            end
            7'b0110011, 7'b0001111: r.kind = IMM_NONE;
            default: r.ill = 1'b1;
        endcase
        if (ins[1:0] != 2'b11) r.ill = 1'b1;
        if (r.ill) begin
            v = 0;
            r.kind = IMM_NONE;
        end
        r.imm = v;
        return r;
    endfunction

    logic [6:0] opcs [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                              7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                              7'b0110011, 7'b0001111, 7'b1110011};

    function automatic logic [31:0] rand_instr(input bit legal_only);
        logic [31:0] r;
        r = $urandom();
        if (!legal_only && $urandom_range(0, 4) == 0) return r;
        return {r[31:7], opcs[$urandom_range(0, 10)]};
    endfunction

    // ---------------- scoreboard ----------------
    // Entries are {pc, instr}; the queue holds everything accepted and not yet
    // delivered, so its depth is also the expected occupancy of the stage.
    logic [63:0] exp_q[$];
    int unsigned m_dec = 0;
    int unsigned m_ill = 0;

    always @(negedge clk) begin
        logic [63:0] e;
        ref_t        r;
        logic [99:0] exp_vec;
        logic [99:0] act_vec;
        if (mon_en && !rst) begin
            n_tests++;
            if (out_valid !== (exp_q.size() > 0)) begin
                n_fail++;
                $display("FAIL sb_out_valid: got %b want %b", out_valid, exp_q.size() > 0);
            end
            n_tests++;
            if (in_ready !== (exp_q.size() < 2)) begin
                n_fail++;
                $display("FAIL sb_in_ready: got %b want %b", in_ready, exp_q.size() < 2);
            end
`ifdef DECODE_PERF_CNT_EN
            n_tests++;
            if (perf_dec_cnt !== m_dec || perf_ill_cnt !== m_ill) begin
                n_fail++;
                $display("FAIL sb_perf: got %0d/%0d want %0d/%0d",
                         perf_dec_cnt, perf_ill_cnt, m_dec, m_ill);
            end
`endif
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q[0];
                r = ref_decode(e[31:0]);
                exp_vec = {e[63:32], e[6:0], e[11:7], e[14:12], e[19:15], e[24:20],
                           e[31:25], r.imm[31:0], r.kind, r.ill};
                act_vec = {out_pc, out_op, out_rd, out_f3, out_rs1, out_rs2, out_f7,
                           out_imm, out_imm_type, out_illegal};
                n_tests++;
                if (act_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL sb_data: got %h want %h", act_vec, exp_vec);
                end
                if (out_ready) begin
                    m_dec++;
                    if (r.ill) m_ill++;
                    void'(exp_q.pop_front());
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back({in_pc, in_instr});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) step();
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        n_tests++;
        if (out_valid !== 1'b0 || out_valid_w !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b/%b want 0/0", out_valid, out_valid_w);
        end
        n_tests++;
        if ({out_pc, out_op, out_rd, out_f3, out_rs1, out_rs2, out_f7, out_imm,
             out_imm_type, out_illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got pc=%h imm=%h type=%0d want all zero, IMM_NONE",
                     out_pc, out_imm, out_imm_type);
        end
        rst   = 1'b0;
        rst_w = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || in_ready_w !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready, in_ready_w);
        end
        mon_en = 1'b1;
        step();
    endtask

    task automatic test_addi();
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 32'h0000_0100;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_rd !== 5'd1 || out_imm !== 32'hFFFFFFFF ||
            out_imm_type !== IMM_I || out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL addi: got v=%b rd=%0d imm=%h type=%0d ill=%b want 1/1/ffffffff/1/0",
                     out_valid, out_rd, out_imm, out_imm_type, out_illegal);
        end
        idle_drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4];
        logic [31:0] eimm [4];
        logic [2:0]  etyp [4];
        ins  = '{32'hFE20AC23, 32'hFE000EE3, 32'h123452B7, 32'h001000EF};
        eimm = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};
        etyp = '{IMM_S, IMM_B, IMM_U, IMM_J};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instr = ins[i];
            in_pc    = 32'h0000_0200 + 32'(i * 4);
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_imm !== eimm[i] || out_imm_type !== etyp[i]) begin
                n_fail++;
                $display("FAIL b2b_%0d: got v=%b imm=%h type=%0d want 1/%h/%0d",
                         i, out_valid, out_imm, out_imm_type, eimm[i], etyp[i]);
            end
        end
        idle_drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] ins [4];
        int idx = 0;
        int cyc = 0;
        bit acc;
        for (int i = 0; i < 4; i++) ins[i] = rand_instr(1'b1);
        while ((idx < 4 || exp_q.size() > 0) && cyc < 40) begin
            in_valid  = (idx < 4);
            in_instr  = ins[idx % 4];
            in_pc     = 32'h0000_2000 + 32'(idx * 4);
            out_ready = (cyc >= 3);
            acc       = in_valid && in_ready;
            if (cyc == 2) begin
                n_tests++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_skid_full: got ready=%b valid=%b want 0/1",
                             in_ready, out_valid);
                end
            end
            step();
            if (acc) idx++;
            cyc++;
        end
        n_tests++;
        if (idx != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got accepted=%0d pending=%0d want 4/0", idx, exp_q.size());
        end
        idle_drain();
    endtask

    task automatic test_illegal();
        int unsigned ill0;
        logic [31:0] ins [2];
        ins  = '{32'h00000000, 32'h0000007F};
        ill0 = m_ill;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_instr = ins[i];
            in_pc    = 32'h0000_3000 + 32'(i * 4);
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_imm !== 32'h0 ||
                out_imm_type !== IMM_NONE) begin
                n_fail++;
                $display("FAIL illegal_%0d: got v=%b ill=%b imm=%h type=%0d want 1/1/0/0",
                         i, out_valid, out_illegal, out_imm, out_imm_type);
            end
        end
        idle_drain();
        n_tests++;
        if (m_ill != ill0 + 2) begin
            n_fail++;
            $display("FAIL illegal_count: got %0d want %0d", m_ill - ill0, 2);
        end
`ifdef DECODE_PERF_CNT_EN
        n_tests++;
        if (perf_ill_cnt !== 32'(ill0 + 2)) begin
            n_fail++;
            $display("FAIL perf_ill: got %0d want %0d", perf_ill_cnt, ill0 + 2);
        end
`endif
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_instr = rand_instr(1'b1);
            in_pc    = 32'h0000_4000 + 32'(i * 4);
            step();
        end
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_prefill: got ready=%b valid=%b want 0/1", in_ready, out_valid);
        end
        flush    = 1'b1;
        in_instr = 32'h00500093;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_full: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        // Second flush with an empty stage: the offered word is accepted by
        // ready but must still be discarded.
        in_instr = 32'h00700113;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_no_deliver_%0d: got valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr(1'b0);
            in_pc     = $urandom();
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            if (flush) out_ready = 1'b0;
            step();
        end
        idle_drain();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got pending=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_xlen64();
        in_valid_w  = 1'b1;
        in_instr_w  = 32'h800002B7;
        in_pc_w     = 64'h0000_0001_0000_0040;
        out_ready_w = 1'b0;
        step();
        in_instr_w = 32'hFFF00093;
        in_pc_w    = 64'h0000_0001_0000_0044;
        n_tests++;
        if (out_valid_w !== 1'b1 || out_imm_w !== 64'hFFFFFFFF80000000 ||
            out_imm_type_w !== IMM_U) begin
            n_fail++;
            $display("FAIL x64_lui: got v=%b imm=%h type=%0d want 1/ffffffff80000000/4",
                     out_valid_w, out_imm_w, out_imm_type_w);
        end
        n_tests++;
        if ({out_pc_w, out_op_w, out_rd_w, out_f3_w, out_rs1_w, out_rs2_w, out_f7_w,
             out_illegal_w} !== {64'h0000_0001_0000_0040, 7'h37, 5'd5, 3'd0, 5'd0,
                                 5'd0, 7'h40, 1'b0}) begin
            n_fail++;
            $display("FAIL x64_fields: got pc=%h op=%h rd=%0d f7=%h ill=%b",
                     out_pc_w, out_op_w, out_rd_w, out_f7_w, out_illegal_w);
        end
        step();
        in_valid_w = 1'b0;
        n_tests++;
        if (in_ready_w !== 1'b0) begin
            n_fail++;
            $display("FAIL x64_skid_full: got ready=%b want 0", in_ready_w);
        end
        #3;
        rst_w = 1'b1;
        #1;
        n_tests++;
        if (out_valid_w !== 1'b0 || in_ready_w !== 1'b1 || out_imm_w !== 64'h0 ||
            out_imm_type_w !== IMM_NONE) begin
            n_fail++;
            $display("FAIL x64_async_rst: got v=%b ready=%b imm=%h type=%0d want 0/1/0/0",
                     out_valid_w, in_ready_w, out_imm_w, out_imm_type_w);
        end
`ifdef DECODE_PERF_CNT_EN
        n_tests++;
        if (perf_dec_cnt_w !== 32'd0 || perf_ill_cnt_w !== 32'd0) begin
            n_fail++;
            $display("FAIL x64_perf_rst: got %0d/%0d want 0/0", perf_dec_cnt_w, perf_ill_cnt_w);
        end
`endif
        #1;
        rst_w = 1'b0;
        out_ready_w = 1'b1;
        step();
        n_tests++;
        if (out_valid_w !== 1'b0) begin
            n_fail++;
            $display("FAIL x64_post_rst: got valid=%b want 0", out_valid_w);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_flush();
        test_random();
        test_xlen64();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
